// File: rtl/fp_pkg.sv
// Shared definitions for the float_MAC datapath:
// default widths, flag bit positions and the MAC frame FSM encoding.
package fp_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;

    localparam int FLAG_NAN = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UF  = 0;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_mul_rne.sv
// Combinational IEEE multiply with round-to-nearest-even.
// Subnormals read as zero, tiny results flush to signed zero.
module fp_mul_rne
    import fp_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] p_o,
    output logic [2:0]   flags_o
);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int MW1  = MAN_W + 1;
    localparam int PW   = 2 * MW1;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic             sa, sb, sp;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb;
    logic [PW-1:0]    prod, norm;
    logic [MW1-1:0]   keep;
    logic             g, s;
    logic [MW1:0]     rnd;
    int               e;

    assign {sa, ea, fa} = a_i;
    assign {sb, eb, fb} = b_i;
    assign sp = sa ^ sb;
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == '1) && (fa == '0);
    assign ib = (eb == '1) && (fb == '0);
    assign na = (ea == '1) && (fa != '0);
    assign nb = (eb == '1) && (fb != '0);
    assign prod = PW'({1'b1, fa}) * PW'({1'b1, fb});

    // Classify specials, otherwise normalise, round and range-check.
    always_comb begin
        p_o     = '0;
        flags_o = '0;
        norm    = '0;
        keep    = '0;
        g       = 1'b0;
        s       = 1'b0;
        rnd     = '0;
        e       = 0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            p_o = QNAN;
            flags_o[FLAG_NAN] = 1'b1;
        end else if (ia || ib) begin
            p_o = {sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (za || zb) begin
            p_o = {sp, {(W-1){1'b0}}};
        end else begin
            norm = prod[PW-1] ? prod : (prod << 1);
            keep = norm[PW-1 -: MW1];
            g    = norm[PW-2-MAN_W];
            s    = |norm[PW-3-MAN_W:0];
            rnd  = {1'b0, keep} + {{MW1{1'b0}}, g & (s | keep[0])};
            e    = int'(ea) + int'(eb) - BIAS
                 + int'(prod[PW-1]) + int'(rnd[MW1]);
            if (e >= EMAX) begin
                p_o = {sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_o[FLAG_OVF] = 1'b1;
            end else if (e <= 0) begin
                p_o = {sp, {(W-1){1'b0}}};
                flags_o[FLAG_UF] = 1'b1;
            end else begin
                p_o = {sp, EXP_W'(e),
                       rnd[MW1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/fp16_mac_stream.sv
// Streaming frame multiply-accumulate: multiply stage, accumulate stage,
// then the frame sum, beat count and sticky flags are held for the collector.
module fp16_mac_stream
    import fp_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    parameter  int CNT_W = 16,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       out_flags
);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int FW   = MAN_W + 4;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t           state_q;
    logic [W-1:0]     acc_q, p_q;
    logic [2:0]       flags_q, pflags_q;
    logic             pv_q, plast_q, out_valid_q;
    logic [CNT_W-1:0] count_q;

    logic [W-1:0]     mul_p, sum;
    logic [2:0]       mul_flags, add_flags;
    logic             accept;

    fp_mul_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mul (
        .a_i    (in_a),
        .b_i    (in_b),
        .p_o    (mul_p),
        .flags_o(mul_flags)
    );

    assign in_ready  = (state_q == ST_ACC) && !RESET && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_flags = flags_q;

    logic             sx, sy, zx, zy, ix, iy, nx, ny, x_big, sg;
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] fx, fy;
    logic [FW-1:0]    mb, ms, msh, df, mn;
    logic [FW:0]      mr;
    logic [MAN_W+1:0] r;
    int               eg, d, e, lz;

    assign {sx, ex, fx} = acc_q;
    assign {sy, ey, fy} = p_q;
    assign zx = (ex == '0);
    assign zy = (ey == '0);
    assign ix = (ex == '1) && (fx == '0);
    assign iy = (ey == '1) && (fy == '0);
    assign nx = (ex == '1) && (fx != '0);
    assign ny = (ey == '1) && (fy != '0);
    assign x_big = ({ex, fx} >= {ey, fy});

    // Accumulator adder: align with guard/round/sticky, normalise, RNE.
    always_comb begin
        sum       = '0;
        add_flags = '0;
        sg  = 1'b0;
        eg  = 0;
        d   = 0;
        e   = 0;
        lz  = 0;
        mb  = '0;
        ms  = '0;
        msh = '0;
        df  = '0;
        mn  = '0;
        mr  = '0;
        r   = '0;
        if (nx || ny || (ix && iy && (sx != sy))) begin
            sum = QNAN;
            add_flags[FLAG_NAN] = 1'b1;
        end else if (ix) begin
            sum = acc_q;
        end else if (iy) begin
            sum = p_q;
        end else if (zx && zy) begin
            sum = {sx & sy, {(W-1){1'b0}}};
        end else if (zx) begin
            sum = p_q;
        end else if (zy) begin
            sum = acc_q;
        end else begin
            sg = x_big ? sx : sy;
            eg = x_big ? int'(ex) : int'(ey);
            d  = eg - (x_big ? int'(ey) : int'(ex));
            mb = x_big ? {1'b1, fx, 3'b000} : {1'b1, fy, 3'b000};
            ms = x_big ? {1'b1, fy, 3'b000} : {1'b1, fx, 3'b000};
            if (d >= FW) begin
                msh = FW'(1);
            end else begin
                msh = ms >> d;
                if ((ms & ((FW'(1) << d) - FW'(1))) != '0)
                    msh[0] = 1'b1;
            end
            if (sx == sy) begin
                mr = {1'b0, mb} + {1'b0, msh};
                mn = mr[FW] ? {mr[FW:2], mr[1] | mr[0]} : mr[FW-1:0];
                e  = eg + int'(mr[FW]);
            end else begin
                df = mb - msh;
                for (int i = 0; i < FW; i++)
                    if (df[i]) lz = FW - 1 - i;
                mn = df << lz;
                e  = eg - lz;
            end
            r = {1'b0, mn[FW-1:3]}
              + {{(MAN_W+1){1'b0}}, mn[2] & (mn[3] | mn[1] | mn[0])};
            e = e + int'(r[MAN_W+1]);
            if ((sx != sy) && (df == '0)) begin
                sum = '0;
            end else if (e >= EMAX) begin
                sum = {sg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                add_flags[FLAG_OVF] = 1'b1;
            end else if (e <= 0) begin
                sum = {sg, {(W-1){1'b0}}};
                add_flags[FLAG_UF] = 1'b1;
            end else begin
                sum = {sg, EXP_W'(e),
                       r[MAN_W+1] ? r[MAN_W:1] : r[MAN_W-1:0]};
            end
        end
    end

    // Product register, accumulator, beat counter and frame FSM.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            p_q         <= '0;
            flags_q     <= '0;
            pflags_q    <= '0;
            pv_q        <= 1'b0;
            plast_q     <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            pv_q <= accept;
            if (accept) begin
                p_q      <= mul_p;
                pflags_q <= mul_flags;
                plast_q  <= in_last;
                if (count_q != '1)
                    count_q <= count_q + CNT_W'(1);
            end
            if (pv_q) begin
                acc_q   <= sum;
                flags_q <= flags_q | pflags_q | add_flags;
            end
            unique case (state_q)
                ST_ACC: begin
                    if (accept && in_last)
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pv_q && plast_q) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        count_q     <= '0;
                        flags_q     <= '0;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mac_stream.sv
// Directed bench for fp16_mac_stream: table of frames with
// hand-computed sums, plus hold, bubble, saturation and abort sequences.
module tb_fp16_mac_stream;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET, clear, in_valid, in_last, out_ready;
    logic [15:0]   in_a, in_b;
    logic          in_ready, out_valid;
    logic [15:0]   out_acc;
    logic [CW-1:0] out_count;
    logic [2:0]    out_flags;

    int errors = 0;
    int checks = 0;

    fp16_mac_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(CW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_count(out_count),
        .out_flags(out_flags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int              n;
        logic [2:0][15:0] a;
        logic [2:0][15:0] b;
        logic [15:0]     acc;
        logic [2:0]      fl;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int n,
                                input logic [15:0] a0, b0, a1, b1, a2, b2,
                                input logic [15:0] r, input logic [2:0] f);
        vec_t v;
        v.n = n;
        v.a[0] = a0; v.b[0] = b0;
        v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2;
        v.acc = r;
        v.fl  = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k == 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        chk({nm, " valid_drop"}, out_valid, 0);
        chk({nm, " in_ready_back"}, in_ready, 1);
        chk({nm, " acc_cleared"}, out_acc, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        for (int i = 0; i < v.n; i++)
            send(v.a[i], v.b[i], i == v.n - 1);
        chk({nm, " valid_n1"}, out_valid, 0);
        @(posedge CLK); #1;
        chk({nm, " valid_n2"}, out_valid, 1);
        chk({nm, " acc"}, out_acc, v.acc);
        chk({nm, " count"}, out_count, v.n);
        chk({nm, " flags"}, out_flags, v.fl);
        handshake(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;

        vecs[0]  = mk(3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                      16'h3C00, 16'h3C00, 16'h4200, 3'b000);
        vecs[1]  = mk(2, 16'h3C00, 16'h4000, 16'hBC00, 16'h4000,
                      16'h0, 16'h0, 16'h0000, 3'b000);
        vecs[2]  = mk(1, 16'h7BFF, 16'h4000, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h7C00, 3'b010);
        vecs[3]  = mk(1, 16'h0400, 16'h0400, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h0000, 3'b001);
        vecs[4]  = mk(2, 16'h7E00, 16'h3C00, 16'h3C00, 16'h3C00,
                      16'h0, 16'h0, 16'h7E00, 3'b100);
        vecs[5]  = mk(1, 16'h3C01, 16'h3C01, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h3C02, 3'b000);
        vecs[6]  = mk(2, 16'h3C00, 16'h3C00, 16'h1000, 16'h3C00,
                      16'h0, 16'h0, 16'h3C00, 3'b000);
        vecs[7]  = mk(2, 16'h3C00, 16'h3C00, 16'h1200, 16'h3C00,
                      16'h0, 16'h0, 16'h3C01, 3'b000);
        vecs[8]  = mk(2, 16'h7C00, 16'h3C00, 16'hFC00, 16'h3C00,
                      16'h0, 16'h0, 16'h7E00, 3'b100);
        vecs[9]  = mk(1, 16'h7C00, 16'h0000, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h7E00, 3'b100);
        vecs[10] = mk(1, 16'hC000, 16'h4000, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'hC400, 3'b000);
        vecs[11] = mk(1, 16'h0001, 16'h3C00, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h0000, 3'b000);
        vecs[12] = mk(1, 16'h8000, 16'h3C00, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h0000, 3'b000);
        vecs[13] = mk(3, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h4000,
                      16'h3C00, 16'h3C00, 16'h7C00, 3'b010);
        vecs[14] = mk(2, 16'h0900, 16'h3C00, 16'h8800, 16'h3C00,
                      16'h0, 16'h0, 16'h0000, 3'b001);

        @(posedge CLK); @(posedge CLK); #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset acc", out_acc, 0);
        chk("reset count", out_count, 0);
        chk("reset flags", out_flags, 0);
        RESET = 1'b0;
        #1;
        chk("post_reset in_ready", in_ready, 1);

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Result held while downstream stalls
        send(16'h4000, 16'h3C00, 1'b1);
        @(posedge CLK); #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d valid", i), out_valid, 1);
            chk($sformatf("hold%0d acc", i), out_acc, 16'h4000);
            chk($sformatf("hold%0d count", i), out_count, 1);
            chk($sformatf("hold%0d in_ready", i), in_ready, 0);
            @(posedge CLK); #1;
        end
        handshake("hold");

        // Bubble mid-frame leaves the accumulator alone
        send(16'h3C00, 16'h3C00, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("bubble valid", out_valid, 0);
        send(16'h3C00, 16'h3C00, 1'b1);
        @(posedge CLK); #1;
        chk("bubble out_valid", out_valid, 1);
        chk("bubble acc", out_acc, 16'h4000);
        chk("bubble count", out_count, 2);
        handshake("bubble");

        // Counter saturates at all-ones, sum stays exact
        for (int i = 0; i < 17; i++)
            send(16'h3C00, 16'h3C00, i == 16);
        @(posedge CLK); #1;
        chk("sat valid", out_valid, 1);
        chk("sat count", out_count, 15);
        chk("sat acc", out_acc, 16'h4C40);
        handshake("sat");

        // RESET after two beats discards the partial frame
        send(16'h3C00, 16'h3C00, 1'b0);
        send(16'h3C00, 16'h3C00, 1'b0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("midreset in_ready", in_ready, 0);
        chk("midreset acc", out_acc, 0);
        chk("midreset count", out_count, 0);
        RESET = 1'b0;
        #1;
        chk("midreset in_ready_back", in_ready, 1);
        run_vec(mk(1, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0,
                   16'h4400, 3'b000), "after_reset");

        // clear wins over a simultaneous beat
        send(16'h3C00, 16'h3C00, 1'b0);
        in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
        clear = 1'b1;
        @(posedge CLK); #1;
        clear = 1'b0; in_valid = 1'b0;
        #1;
        chk("clear acc", out_acc, 0);
        chk("clear count", out_count, 0);
        run_vec(mk(1, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0,
                   16'h4400, 3'b000), "after_clear");

        // clear while holding a result drops it
        send(16'h3C00, 16'h3C00, 1'b1);
        @(posedge CLK); #1;
        chk("clrhold valid", out_valid, 1);
        clear = 1'b1;
        @(posedge CLK); #1;
        clear = 1'b0;
        #1;
        chk("clrhold valid_drop", out_valid, 0);
        chk("clrhold acc", out_acc, 0);
        chk("clrhold in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
